// File: rtl/kgp_diff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_diff_pkg
// Description : Shared constants and FSM state type for the KGP-RISC
//               difference unit (diff_arbiter and its slice encoder).
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_diff_pkg;

  localparam int DATA_W     = 32;
  localparam int RES_W      = 6;
  localparam int SLICE_W    = 8;
  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int K_W        = $clog2(NUM_SLICES);
  localparam int IDX_W      = $clog2(SLICE_W);

  // Result reported when the two operands are identical.
  localparam logic [RES_W-1:0] EQUAL_POS = 6'd32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : kgp_diff_pkg
`default_nettype wire

// File: rtl/diff_slice_encoder.sv
`default_nettype none
// ============================================================================
// Module      : diff_slice_encoder
// Description : Combinational lowest-set-bit finder for one 8-bit slice.
//               idx is the position of the lowest 1 bit; nz flags that any
//               bit is set (idx is 0 when the slice is all zero).
// Revision    : 1.0 - initial release
// ============================================================================
module diff_slice_encoder
  import kgp_diff_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  output logic [IDX_W-1:0]   idx,
  output logic               nz
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    nz  = |slice;
    for (int i = SLICE_W - 1; i >= 0; i--) begin
      if (slice[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule : diff_slice_encoder
`default_nettype wire

// File: rtl/diff_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : diff_arbiter
// Description : Two-port round-robin front end for the difference unit.
//               The winning request's operands are XORed and scanned one
//               8-bit slice per cycle (early exit on the first non-zero
//               slice); the tagged result is returned on a valid/ready
//               response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module diff_arbiter
  import kgp_diff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_pos,
  output logic              rsp_equal
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_x;
  logic                r_id;
  logic [K_W-1:0]      r_k;
  logic [RES_W-1:0]    r_pos;
  logic                r_equal;

  logic                w_winner;
  logic                w_any_valid;
  logic                w_accept;
  logic [DATA_W-1:0]   w_x_in;
  logic [SLICE_W-1:0]  w_slice;
  logic [IDX_W-1:0]    w_idx;
  logic                w_nz;
  logic                w_last_slice;

  // Round-robin pick: a lone requester always wins; on contention the port
  // that was not granted last time goes first.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = req1_valid;
    end
    req0_ready = (r_state == IDLE) && w_any_valid && !w_winner;
    req1_ready = (r_state == IDLE) && w_any_valid &&  w_winner;
    w_accept   = req0_ready | req1_ready;
    w_x_in     = w_winner ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
  end

  // Select the slice currently being examined.
  always_comb begin
    w_slice      = r_x[{r_k, 3'b000} +: SLICE_W];
    w_last_slice = (r_k == K_W'(NUM_SLICES - 1));
  end

  diff_slice_encoder u_enc (
    .slice (w_slice),
    .idx   (w_idx),
    .nz    (w_nz)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_nz || w_last_slice) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, slice counter and round-robin pointer. Reset favours
  // port 0 on the first contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_x          <= '0;
      r_id         <= 1'b0;
      r_k          <= '0;
    end else begin
      if (w_accept) begin
        r_x          <= w_x_in;
        r_id         <= w_winner;
        r_k          <= '0;
        r_last_grant <= w_winner;
      end else if ((r_state == SCAN) && !w_nz && !w_last_slice) begin
        r_k <= r_k + K_W'(1);
      end
    end
  end

  // Result registers; written only on leaving SCAN so they hold through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos   <= '0;
      r_equal <= 1'b0;
    end else if (r_state == SCAN) begin
      if (w_nz) begin
        r_pos   <= {1'b0, r_k, w_idx};
        r_equal <= 1'b0;
      end else if (w_last_slice) begin
        r_pos   <= EQUAL_POS;
        r_equal <= 1'b1;
      end
    end
  end

  // Response channel drive.
  always_comb begin
    rsp_valid = (r_state == RESP);
    rsp_id    = r_id;
    rsp_pos   = r_pos;
    rsp_equal = r_equal;
  end

endmodule : diff_arbiter
`default_nettype wire

// File: tb/tb_diff_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_diff_arbiter
// Description : Self-checking bench for diff_arbiter: directed and random
//               transactions compared against a bit-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diff_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_equal;
  logic [5:0]  rsp_pos;

  int n_checks = 0;
  int n_errors = 0;
  bit last_grant = 1'b1;

  diff_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_pos    (rsp_pos),
    .rsp_equal  (rsp_equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: lowest differing bit, 32 when equal.
  function automatic int ref_pos(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    for (int i = 0; i < 32; i++) if (x[i]) return i;
    return 32;
  endfunction

  function automatic int ref_lat(input int pos);
    return (pos == 32) ? 5 : (pos / 8) + 2;
  endfunction

  // Random operand pair whose first difference lands at a random position.
  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int p;
    logic [31:0] x;
    p = $urandom_range(0, 32);
    x = (p == 32) ? 32'd0 : (($urandom() | 32'd1) << p);
    a = $urandom();
    b = a ^ x;
  endtask

  // One transaction; must be called at a negedge with the DUT in IDLE.
  task automatic txn(input bit u0, input bit u1, input bit keep, input int stall);
    int  w, lat, epos;
    bit  ep;
    logic [5:0] hpos;
    logic       heq, hid;
    req0_valid = u0;
    req1_valid = u1;
    rsp_ready  = (stall == 0);
    #1;
    w = 0;
    while (!(req0_ready || req1_ready) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check("grant_seen", 32'(req0_ready || req1_ready), 1);
    ep = (u0 && u1) ? ~last_grant : u1;
    check("req0_ready", 32'(req0_ready), 32'(!ep));
    check("req1_ready", 32'(req1_ready), 32'(ep));
    epos = ep ? ref_pos(req1_a, req1_b) : ref_pos(req0_a, req0_b);
    last_grant = ep;
    @(posedge clk);
    @(negedge clk);
    if (keep) begin
      if (ep) gen(req1_a, req1_b); else gen(req0_a, req0_b);
    end else begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      check("busy_ready", {30'd0, req0_ready, req1_ready}, 0);
      @(negedge clk);
      lat++;
    end
    check("latency",   lat, ref_lat(epos));
    check("rsp_pos",   32'(rsp_pos), epos);
    check("rsp_equal", 32'(rsp_equal), 32'(epos == 32));
    check("rsp_id",    32'(rsp_id), 32'(ep));
    check("resp_ready", {30'd0, req0_ready, req1_ready}, 0);
    hpos = rsp_pos; heq = rsp_equal; hid = rsp_id;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_pos",   32'(rsp_pos), 32'(hpos));
      check("stall_eq",    32'(rsp_equal), 32'(heq));
      check("stall_id",    32'(rsp_id), 32'(hid));
      check("stall_ready", {30'd0, req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("back_idle", 32'(rsp_valid), 0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_pos",   32'(rsp_pos), 0);
    check("rst_equal", 32'(rsp_equal), 0);
    check("rst_id",    32'(rsp_id), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_noready", {30'd0, req0_ready, req1_ready}, 0);

    // Port 0 only, slice 0 hit.
    req0_a = 32'd15; req0_b = 32'd0;
    txn(1, 0, 0, 0);
    // Port 1 only, slice boundaries.
    req1_a = 32'd512; req1_b = 32'd0; txn(0, 1, 0, 0);
    req1_a = 32'd64;  req1_b = 32'd0; txn(0, 1, 0, 0);
    req1_a = 32'd69;  req1_b = 32'd0; txn(0, 1, 0, 0);
    // Equal operands.
    req0_a = 32'hDEADBEEF; req0_b = 32'hDEADBEEF; txn(1, 0, 0, 0);
    // Both valid continuously: alternating grants.
    gen(req0_a, req0_b); gen(req1_a, req1_b);
    for (int i = 0; i < 4; i++) txn(1, 1, 1, 0);
    req0_valid = 0; req1_valid = 0;
    // Backpressure in RESP.
    gen(req1_a, req1_b);
    txn(0, 1, 0, 6);

    // Reset while scanning slice 1 of a slice-3 result.
    req0_a = 32'h80000000; req0_b = 32'd0;
    req0_valid = 1; #1;
    check("pre_rst_grant", 32'(req0_ready), 1);
    @(posedge clk); @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    last_grant = 1'b1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_pos",   32'(rsp_pos), 0);
    check("mid_rst_eq",    32'(rsp_equal), 0);
    w = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) w++;
    end
    check("no_stale_rsp", w, 0);
    req1_a = 32'h00F00000; req1_b = 32'd0; txn(0, 1, 0, 0);
    // Pointer restored by reset: port 0 gets the first contended grant.
    last_grant = 1'b1;
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    gen(req0_a, req0_b); gen(req1_a, req1_b);
    txn(1, 1, 0, 0);

    // Random mix of ports, operands and short stalls.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      gen(req0_a, req0_b); gen(req1_a, req1_b);
      txn(sel[0], sel[1], 0, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_diff_arbiter
`default_nettype wire
